// File: rtl/dram_wb_arbiter.sv
// Round-robin N-port Wishbone arbiter onto one LiteDRAM user port, with timeout-to-error.
// Define DRAM_ARB_PERF_EN to add saturating read/write/error counters.
module dram_wb_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int WORD_SIZE      = 256,
    parameter int ADDR_WIDTH     = 25,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                      user_clk,
    input  logic                                      user_rst,
    input  logic                                      initialized_i,
    input  logic [NUM_PORTS-1:0]                      cyc_i,
    input  logic [NUM_PORTS-1:0]                      stb_i,
    input  logic [NUM_PORTS-1:0]                      we_i,
    input  logic [NUM_PORTS-1:0][31:0]                addr_i,
    input  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]       data_i,
    input  logic [NUM_PORTS-1:0][WORD_SIZE/8-1:0]     sel_i,
    output logic [WORD_SIZE-1:0]                      data_o,
    output logic [NUM_PORTS-1:0]                      ack_o,
    output logic [NUM_PORTS-1:0]                      err_o,
    output logic [GW-1:0]                             grant_o,
    output logic                                      dram_cyc_o,
    output logic                                      dram_stb_o,
    output logic                                      dram_we_o,
    output logic [ADDR_WIDTH-1:0]                     dram_adr_o,
    output logic [WORD_SIZE-1:0]                      dram_dat_w_o,
    output logic [WORD_SIZE/8-1:0]                    dram_sel_o,
    input  logic [WORD_SIZE-1:0]                      dram_dat_r_i,
    input  logic                                      dram_ack_i,
    input  logic                                      dram_err_i
`ifdef DRAM_ARB_PERF_EN
    ,
    output logic [31:0]                               perf_rd_count_o,
    output logic [31:0]                               perf_wr_count_o,
    output logic [31:0]                               perf_err_count_o
`endif
);

    localparam int OFFSET = $clog2(WORD_SIZE / 8);
    localparam logic [31:0] TO_LAST =
        32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [WORD_SIZE-1:0]   dw_q, dw_d;
    logic [WORD_SIZE/8-1:0] sel_q, sel_d;
    logic [WORD_SIZE-1:0]   data_q, data_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [NUM_PORTS-1:0]   err_q, err_d;
    logic [GW-1:0]          gnt_q, gnt_d;
    logic [GW-1:0]          last_q, last_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   aband_q, aband_d;

    logic [NUM_PORTS-1:0]   req;
    logic [GW-1:0]          pick;
    logic [GW-1:0]          idx;
    logic                   found;
    logic                   drop;
    logic                   tmo;
    logic                   unused_ok;

    assign req       = cyc_i & stb_i;
    assign unused_ok = ^addr_i;
    assign tmo       = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dw_d    = dw_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ack_d   = '0;
        err_d   = '0;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        aband_d = aband_q;
        pick    = '0;
        idx     = '0;
        found   = 1'b0;
        drop    = aband_q | ~cyc_i[gnt_q];

        // first requester after the last grant, wrapping around
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = GW'((int'(last_q) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (initialized_i && found) begin
                    we_d    = we_i[pick];
                    adr_d   = addr_i[pick][OFFSET +: ADDR_WIDTH];
                    dw_d    = data_i[pick];
                    sel_d   = sel_i[pick];
                    cyc_d   = 1'b1;
                    gnt_d   = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    aband_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                aband_d = drop;
                if (dram_ack_i) begin
                    data_d       = dram_dat_r_i;
                    ack_d[gnt_q] = ~drop;
                    cyc_d        = 1'b0;
                    we_d         = 1'b0;
                    state_d      = RESP;
                end else if (dram_err_i || tmo) begin
                    err_d[gnt_q] = ~drop;
                    cyc_d        = 1'b0;
                    we_d         = 1'b0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dw_q    <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            gnt_q   <= '0;
            last_q  <= GW'(NUM_PORTS - 1);
            cnt_q   <= '0;
            aband_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dw_q    <= dw_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            aband_q <= aband_d;
        end
    end

    assign data_o       = data_q;
    assign ack_o        = ack_q;
    assign err_o        = err_q;
    assign grant_o      = gnt_q;
    assign dram_cyc_o   = cyc_q;
    assign dram_stb_o   = cyc_q;
    assign dram_we_o    = we_q;
    assign dram_adr_o   = adr_q;
    assign dram_dat_w_o = dw_q;
    assign dram_sel_o   = sel_q;

`ifdef DRAM_ARB_PERF_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    // we_q still holds the finishing access's direction on the ack cycle
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (|ack_d && !we_q && rd_cnt_q != 32'hFFFF_FFFF)
                rd_cnt_q <= rd_cnt_q + 32'd1;
            if (|ack_d && we_q && wr_cnt_q != 32'hFFFF_FFFF)
                wr_cnt_q <= wr_cnt_q + 32'd1;
            if (|err_d && err_cnt_q != 32'hFFFF_FFFF)
                err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign perf_rd_count_o  = rd_cnt_q;
    assign perf_wr_count_o  = wr_cnt_q;
    assign perf_err_count_o = err_cnt_q;
`else
    // counters absent in this build
`endif

endmodule

// File: tb/tb_dram_wb_arbiter.sv
// Directed bench for dram_wb_arbiter with a transaction-level reference model.
// Build with DRAM_ARB_PERF_EN to also exercise the performance counters.
`timescale 1ns/1ps
module tb_dram_wb_arbiter;

    localparam int NP = 4;
    localparam int WS = 256;
    localparam int AW = 25;
    localparam int TO = 16;
    localparam int SW = WS / 8;
    localparam int OFF = 5;

    logic clk = 1'b0;
    logic rst;
    logic init;
    logic [NP-1:0] cyc, stb, we;
    logic [NP-1:0][31:0] addr;
    logic [NP-1:0][WS-1:0] wdat;
    logic [NP-1:0][SW-1:0] sel;
    logic [WS-1:0] data_o;
    logic [NP-1:0] ack_o, err_o;
    logic [1:0] grant_o;
    logic d_cyc, d_stb, d_we;
    logic [AW-1:0] d_adr;
    logic [WS-1:0] d_dw, d_dr;
    logic [SW-1:0] d_sel;
    logic d_ack, d_err;
`ifdef DRAM_ARB_PERF_EN
    logic [31:0] p_rd, p_wr, p_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    bit go = 1'b0;

    dram_wb_arbiter #(
        .NUM_PORTS(NP), .WORD_SIZE(WS),
        .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .user_clk(clk), .user_rst(rst), .initialized_i(init),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .addr_i(addr),
        .data_i(wdat), .sel_i(sel), .data_o(data_o),
        .ack_o(ack_o), .err_o(err_o), .grant_o(grant_o),
        .dram_cyc_o(d_cyc), .dram_stb_o(d_stb), .dram_we_o(d_we),
        .dram_adr_o(d_adr), .dram_dat_w_o(d_dw), .dram_sel_o(d_sel),
        .dram_dat_r_i(d_dr), .dram_ack_i(d_ack), .dram_err_i(d_err)
`ifdef DRAM_ARB_PERF_EN
        , .perf_rd_count_o(p_rd), .perf_wr_count_o(p_wr),
        .perf_err_count_o(p_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(string name, logic [WS-1:0] act, logic [WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DRAM responder: ack (or err) 'lat' cycles after stb is seen; lat<0 never answers
    int lat = 0;
    bit use_err = 1'b0;
    int dcnt = 0;
    always @(posedge clk) begin
        #1;
        if (d_stb && !d_ack && !d_err) begin
            if (lat >= 0 && dcnt == lat) begin
                if (use_err) d_err = 1'b1;
                else d_ack = 1'b1;
            end else begin
                dcnt++;
            end
        end else begin
            d_ack = 1'b0;
            d_err = 1'b0;
            dcnt = 0;
        end
    end

    // Reference model: one owner at a time, one quiet cycle after each completion
    int owner, waited, last_p;
    bit cooldown, gone;
    logic [NP-1:0] e_ack, e_err;
    logic e_cyc, e_we;
    logic [AW-1:0] e_adr;
    logic [WS-1:0] e_dw, e_data;
    logic [SW-1:0] e_sel;
    logic [1:0] e_grant;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = -1; waited = 0; last_p = NP - 1;
            cooldown = 0; gone = 0;
            e_ack = '0; e_err = '0; e_cyc = 0; e_we = 0;
            e_adr = '0; e_dw = '0; e_data = '0; e_sel = '0; e_grant = '0;
        end else begin
            e_ack = '0;
            e_err = '0;
            if (cooldown) begin
                cooldown = 0;
            end else if (owner >= 0) begin
                if (!cyc[owner]) gone = 1;
                if (d_ack || d_err || waited == TO - 1) begin
                    if (d_ack) begin
                        e_data = d_dr;
                        if (!gone) e_ack[owner] = 1'b1;
                    end else if (!gone) begin
                        e_err[owner] = 1'b1;
                    end
                    e_cyc = 0; e_we = 0;
                    owner = -1; cooldown = 1;
                end else begin
                    waited++;
                end
            end else if (init) begin
                for (int k = 1; k <= NP; k++) begin
                    if (owner < 0 && cyc[(last_p + k) % NP] && stb[(last_p + k) % NP])
                        owner = (last_p + k) % NP;
                end
                if (owner >= 0) begin
                    last_p = owner;
                    e_grant = 2'(owner);
                    e_cyc = 1; e_we = we[owner];
                    e_adr = addr[owner][OFF +: AW];
                    e_dw = wdat[owner]; e_sel = sel[owner];
                    waited = 0; gone = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("ctl", {d_cyc, d_stb, d_we, grant_o, ack_o, err_o},
                {e_cyc, e_cyc, e_we, e_grant, e_ack, e_err});
            chk("adr", d_adr, e_adr);
            chk("wdat", d_dw, e_dw);
            chk("sel", d_sel, e_sel);
            chk("rdata", data_o, e_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(int p, bit w, logic [31:0] a, logic [WS-1:0] d, logic [SW-1:0] s);
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w;
        addr[p] = a; wdat[p] = d; sel[p] = s;
    endtask

    task automatic drop(int p);
        cyc[p] = 1'b0;
        stb[p] = 1'b0;
    endtask

    task automatic wait_stb(output int t);
        bit ok = 0;
        t = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (d_stb) begin ok = 1; t = cyc_n; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_stb: dram_stb_o stayed 0, required 1 within 8 cycles");
        end
    endtask

    task automatic wait_resp(int p, int maxc, output int t);
        bit ok = 0;
        t = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (ack_o[p] || err_o[p]) begin ok = 1; t = cyc_n; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_resp: port %0d got no ack/err, required one within %0d cycles", p, maxc);
        end
    endtask

    task automatic txn(int p, bit w, logic [31:0] a);
        int t;
        req(p, w, a, WS'(a) + 1, '1);
        wait_resp(p, 40, t);
        tick();
        drop(p);
    endtask

    initial begin
        int t0, t1, n;
        int order[5];
        int exp_order[5];
        bit seen;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1; init = 0; cyc = '0; stb = '0; we = '0;
        addr = '0; wdat = '0; sel = '0;
        d_ack = 0; d_err = 0; d_dr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        go = 1;
        chk("rst_cyc", d_cyc, 0);
        chk("rst_ack_err", {ack_o, err_o}, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_rdata", data_o, 0);
        tick();
        rst = 0;

        // requests pending while DRAM not initialised
        for (int p = 0; p < NP; p++) req(p, 0, 32'(p * 32'h20), '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("init_gate", d_cyc, 0);
        end

        // round-robin, immediate DRAM ack
        lat = 0;
        d_dr = 256'h77;
        tick();
        init = 1;
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            if (|ack_o) begin
                for (int p = 0; p < NP; p++) if (ack_o[p]) order[n] = p;
                chk("rr_onehot", 256'($onehot(ack_o)), 1);
                n++;
            end
        end
        chk("rr_count", n, 5);
        for (int i = 0; i < 5; i++) chk("rr_order", order[i], exp_order[i]);
        tick();
        for (int p = 0; p < NP; p++) drop(p);

        // single read on port 1, ack three edges after grant
        lat = 2;
        d_dr = 256'hA5;
        tick();
        req(1, 0, 32'h0000_0040, '0, '0);
        wait_stb(t0);
        chk("rd_adr", d_adr, 2);
        chk("rd_we", d_we, 0);
        wait_resp(1, 10, t1);
        chk("rd_ack", ack_o, 4'b0010);
        chk("rd_data", data_o, 256'hA5);
        chk("rd_lat", t1 - t0, 3);
        tick();
        drop(1);
        @(negedge clk);
        chk("rd_pulse", ack_o, 0);

        // byte-enable write on port 2
        lat = 3;
        tick();
        req(2, 1, 32'h0000_0100, 256'h1234, 32'h0000_000F);
        wait_stb(t0);
        chk("wr_sel", d_sel, 32'h0000_000F);
        chk("wr_dat", d_dw, 256'h1234);
        chk("wr_we", d_we, 1);
        chk("wr_adr", d_adr, 8);
        wait_resp(2, 10, t1);
        chk("wr_ack", ack_o, 4'b0100);
        tick();
        drop(2);

        // timeout: DRAM never answers
        lat = -1;
        tick();
        req(3, 0, 32'h0000_0200, '0, '0);
        wait_stb(t0);
        wait_resp(3, 40, t1);
        chk("to_err", err_o, 4'b1000);
        chk("to_noack", ack_o, 0);
        chk("to_lat", t1 - t0, TO);
        tick();
        drop(3);
        @(negedge clk);
        chk("to_cyc", d_cyc, 0);

        // next request served normally
        lat = 0;
        d_dr = 256'hBEEF;
        tick();
        req(0, 0, 32'h0000_0020, '0, '0);
        wait_resp(0, 10, t1);
        chk("post_to_ack", ack_o, 4'b0001);
        chk("post_to_data", data_o, 256'hBEEF);
        tick();
        drop(0);

        // DRAM error path
        lat = 1;
        use_err = 1;
        tick();
        req(1, 0, 32'h0000_0060, '0, '0);
        wait_resp(1, 10, t1);
        chk("derr_err", err_o, 4'b0010);
        tick();
        drop(1);
        use_err = 0;

        // abandoned cycle: access completes, no ack to requester
        lat = 4;
        tick();
        req(2, 0, 32'h0000_0080, '0, '0);
        wait_stb(t0);
        tick();
        drop(2);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (|{ack_o, err_o}) seen = 1;
        end
        chk("aband_quiet", seen, 0);
        chk("aband_idle", d_cyc, 0);

        // asynchronous reset during an access
        lat = -1;
        tick();
        req(3, 1, 32'h0000_00A0, 256'h55, '1);
        wait_stb(t0);
        repeat (2) tick();
        rst = 1;
        #1;
        chk("rst_mid_cyc", d_cyc, 0);
        chk("rst_mid_stb", d_stb, 0);
        chk("rst_mid_ack_err", {ack_o, err_o}, 0);
        drop(3);
        tick();
        rst = 0;
        lat = 0;

`ifdef DRAM_ARB_PERF_EN
        txn(0, 0, 32'h0000_0000);
        txn(1, 0, 32'h0000_0020);
        txn(2, 0, 32'h0000_0040);
        txn(3, 1, 32'h0000_0060);
        txn(0, 1, 32'h0000_0080);
        use_err = 1;
        txn(1, 0, 32'h0000_00A0);
        use_err = 0;
        repeat (2) tick();
        chk("perf_rd", p_rd, 3);
        chk("perf_wr", p_wr, 2);
        chk("perf_err", p_err, 1);
`else
        txn(1, 0, 32'h0000_0020);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
